rcb_alloc: RTL and testbench
============================

RCB_ALLOC -- requirements
Module: rcb_alloc

Interface
REQ-001 SHALL have parameter NN, default 4: number of input ports.
REQ-002 SHALL have parameter MN, default 4: number of output ports.
REQ-003 SHALL have parameter DW, default 8: data width per port.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port ivalid  input  NN: per-input flit valid.
REQ-007 SHALL have port idata  input  NN x DW: per-input flit data.
REQ-008 SHALL have port idst  input  NN x MN: per-input destination; one-hot, sampled only while the input holds no grant.
REQ-009 SHALL have port itail  input  NN: per-input last-flit-of-packet flag.
REQ-010 SHALL have port iready  output  NN: per-input accept.
REQ-011 SHALL have port ovalid  output  MN: per-output flit valid.
REQ-012 SHALL have port odata  output  MN x DW: per-output flit data.
REQ-013 SHALL have port otail  output  MN: per-output tail flag.
REQ-014 SHALL have port oready  input  MN: per-output downstream accept.
REQ-015 SHALL have port cfg  output  MN x NN: registered crossbar configuration; cfg[i][k]=1 means output i is owned by input k.

Function
REQ-016 SHALL keep one two-state FSM per output: IDLE (no owner) and BUSY (owner registered).
REQ-017 In IDLE, output i SHALL arbitrate round-robin among inputs k with ivalid[k]=1, idst[k][i]=1 and k not owning any output.
REQ-018 On a win, the output SHALL enter BUSY at the next edge, set cfg[i][winner]=1 and clear all other bits of cfg[i].
REQ-019 Grant latency SHALL be exactly one cycle: head valid in cycle N gives ovalid in cycle N+1 at the earliest.
REQ-020 In BUSY, datapath SHALL be combinational through cfg: ovalid[i]=ivalid[k], odata[i]=idata[k], otail[i]=itail[k], iready[k]=oready[i].
REQ-021 Inputs without a grant SHALL drive iready=0; IDLE outputs SHALL drive ovalid=0, odata=0, otail=0.
REQ-022 A transfer SHALL occur only when ovalid[i] and oready[i] are both 1 in the same cycle.
REQ-023 A transfer with otail=1 SHALL return the output to IDLE at the next edge and clear cfg[i].
REQ-024 After a release, the round-robin pointer of output i SHALL move to (owner+1) mod NN; lower index wins ties relative to the pointer.
REQ-025 An output released in cycle N SHALL NOT grant in cycle N; it arbitrates again from cycle N+1, with a new owner valid from N+2.
REQ-026 A single-flit packet (head=tail) SHALL be legal and SHALL cause exactly one transfer then release.
REQ-027 If idst[k] is not one-hot, only its lowest-index set bit SHALL be used.
REQ-028 ivalid dropping mid-packet SHALL hold the grant; the output stays BUSY with ovalid=0.
REQ-029 Each column of cfg SHALL have at most one bit set, and each row SHALL have at most one bit set.

Reset
REQ-030 While rst=1 at an edge, every FSM SHALL go to IDLE, cfg=0 and all round-robin pointers=0.
REQ-031 Outputs after reset SHALL be iready=0, ovalid=0, odata=0, otail=0; a packet cut by mid-operation reset is dropped with no recovery.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, BUSY) and a one-hot-to-index function.
REQ-033 The round-robin arbiter SHALL be a separate sub-module rr_arb (parameter N; req, ptr in; one-hot gnt out), instantiated once per output.

Verification (NN=MN=4, DW=8)
REQ-034 Input 0 sends a 3-flit packet 0x11,0x22,0x33 to output 2 with oready=1 -> ovalid[2] in cycles 1-3 with the same data, cfg[2]=0001 in cycles 1-3, cfg[2]=0 in cycle 4.
REQ-035 Inputs 1 and 3 request output 0 in cycle 0 with pointer 0 -> input 1 granted; after input 1's tail, input 3 is granted two cycles later.
REQ-036 Input 2 sends a single-flit packet 0xA5 to output 1 with oready[1]=0 for 3 cycles -> ovalid=1 and odata=0xA5 held; release occurs one cycle after oready rises.
REQ-037 Four inputs target four distinct outputs in the same cycle -> all are granted in cycle 1 and cfg is a permutation matrix.
REQ-038 rst is asserted in the middle of packet flit 2 -> next cycle cfg=0 and all outputs are 0; a new head is granted normally afterwards.
REQ-039 Input 0 has idst=0110 -> only output 1 is granted.

Source files
------------

// File: rtl/rcb_alloc_pkg.sv
// Shared types and helpers for the rcb_alloc crossbar allocator.
package rcb_alloc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ost_t;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic int unsigned oh2idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned b = 32; b > 0; b--) begin
            if (oh[b-1]) idx = b - 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rcb_alloc_rr_arb.sv
// Round-robin arbiter: the first requester at or after ptr (wrapping) wins.
module rr_arb #(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (!found && req[k] && (k == (32'(ptr) + off) % N)) begin
                    gnt[k] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rcb_alloc.sv
// Per-output packet allocator: one IDLE/BUSY owner FSM and round-robin arbiter
// per output, with the flit datapath steered combinationally through cfg.
module rcb_alloc
    import rcb_alloc_pkg::*;
#(
    parameter int unsigned NN = 4,
    parameter int unsigned MN = 4,
    parameter int unsigned DW = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             ivalid,
    input  logic [NN-1:0][DW-1:0]     idata,
    input  logic [NN-1:0][MN-1:0]     idst,
    input  logic [NN-1:0]             itail,
    output logic [NN-1:0]             iready,
    output logic [MN-1:0]             ovalid,
    output logic [MN-1:0][DW-1:0]     odata,
    output logic [MN-1:0]             otail,
    input  logic [MN-1:0]             oready,
    output logic [MN-1:0][NN-1:0]     cfg
);

    localparam int unsigned PW = (NN > 1) ? $clog2(NN) : 1;

    ost_t                  state   [MN];
    ost_t                  state_n [MN];
    logic [MN-1:0][NN-1:0] cfg_n;
    logic [MN-1:0][NN-1:0] reqm;
    logic [MN-1:0][NN-1:0] gnt;
    logic [MN-1:0][PW-1:0] ptr;
    logic [MN-1:0][PW-1:0] ptr_n;
    logic [NN-1:0]         owns;
    logic [NN-1:0][MN-1:0] dlow;

    // Non-one-hot destinations collapse to their lowest set bit.
    always_comb begin
        owns = '0;
        for (int unsigned k = 0; k < NN; k++) begin
            dlow[k] = idst[k] & (~idst[k] + MN'(1));
            for (int unsigned i = 0; i < MN; i++) begin
                owns[k] = owns[k] | cfg[i][k];
            end
        end
    end

    always_comb begin
        reqm = '0;
        for (int unsigned i = 0; i < MN; i++) begin
            for (int unsigned k = 0; k < NN; k++) begin
                reqm[i][k] = ivalid[k] & dlow[k][i] & ~owns[k];
            end
        end
    end

    for (genvar g = 0; g < MN; g++) begin : g_arb
        rr_arb #(.N(NN)) u_arb (
            .req (reqm[g]),
            .ptr (ptr[g]),
            .gnt (gnt[g])
        );
    end

    always_comb begin
        iready = '0;
        ovalid = '0;
        odata  = '0;
        otail  = '0;
        for (int unsigned i = 0; i < MN; i++) begin
            for (int unsigned k = 0; k < NN; k++) begin
                if (cfg[i][k]) begin
                    ovalid[i] = ivalid[k];
                    odata[i]  = idata[k];
                    otail[i]  = itail[k];
                    iready[k] = oready[i];
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        cfg_n   = cfg;
        ptr_n   = ptr;
        for (int unsigned i = 0; i < MN; i++) begin
            case (state[i])
                IDLE: begin
                    if (|gnt[i]) begin
                        state_n[i] = BUSY;
                        cfg_n[i]   = gnt[i];
                    end
                end
                BUSY: begin
                    if (ovalid[i] && oready[i] && otail[i]) begin
                        state_n[i] = IDLE;
                        cfg_n[i]   = '0;
                        ptr_n[i]   = PW'((oh2idx(32'(cfg[i])) + 32'd1) % NN);
                    end
                end
                default: state_n[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MN; i++) state[i] <= IDLE;
            cfg <= '0;
            ptr <= '0;
        end else begin
            state <= state_n;
            cfg   <= cfg_n;
            ptr   <= ptr_n;
        end
    end

endmodule

// File: tb/tb_rcb_alloc.sv
// Bench for rcb_alloc: directed vector table plus randomized traffic, all
// checked against an owner/pointer reference model.
module tb_rcb_alloc;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      ivalid, itail, iready, ovalid, otail, oready;
    logic [3:0][7:0] idata, odata;
    logic [3:0][3:0] idst, cfg;

    int tests  = 0;
    int failed = 0;

    int own [4];
    int rp  [4];

    typedef struct {
        bit          r;
        logic [3:0]  iv;
        logic [31:0] id;
        logic [15:0] ds;
        logic [3:0]  it;
        logic [3:0]  ord;
        bit          c;
        logic [3:0]  eov;
        logic [31:0] eod;
        logic [3:0]  eot;
        logic [15:0] ecf;
        logic [3:0]  eir;
    } vec_t;

    vec_t tbl[$];

    rcb_alloc #(.NN(4), .MN(4), .DW(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .ivalid (ivalid),
        .idata  (idata),
        .idst   (idst),
        .itail  (itail),
        .iready (iready),
        .ovalid (ovalid),
        .odata  (odata),
        .otail  (otail),
        .oready (oready),
        .cfg    (cfg)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(bit r, logic [3:0] iv, logic [31:0] id, logic [15:0] ds,
                                 logic [3:0] it, logic [3:0] ord, bit c, logic [3:0] eov,
                                 logic [31:0] eod, logic [3:0] eot, logic [15:0] ecf,
                                 logic [3:0] eir);
        vec_t v;
        v.r = r; v.iv = iv; v.id = id; v.ds = ds; v.it = it; v.ord = ord; v.c = c;
        v.eov = eov; v.eod = eod; v.eot = eot; v.ecf = ecf; v.eir = eir;
        return v;
    endfunction

    function automatic int lowbit(input logic [3:0] v);
        for (int b = 0; b < 4; b++) if (v[b]) return b;
        return -1;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            own[i] = -1;
            rp[i]  = 0;
        end
    endtask

    task automatic model_exp(output logic [3:0] eir, output logic [3:0] eov,
                             output logic [3:0] eot, output logic [31:0] eod,
                             output logic [15:0] ecf);
        int k;
        eir = '0; eov = '0; eot = '0; eod = '0; ecf = '0;
        for (int i = 0; i < 4; i++) begin
            if (own[i] >= 0) begin
                k = own[i];
                eov[i]         = ivalid[k];
                eod[i*8 +: 8]  = idata[k];
                eot[i]         = itail[k];
                eir[k]         = oready[i];
                ecf[i*4 + k]   = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        int  nown [4];
        bit  held [4];
        int  k;
        if (rst) begin
            model_reset();
            return;
        end
        for (int j = 0; j < 4; j++) held[j] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nown[i] = own[i];
            if (own[i] >= 0) held[own[i]] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (own[i] >= 0) begin
                k = own[i];
                if (ivalid[k] && oready[i] && itail[k]) begin
                    nown[i] = -1;
                    rp[i]   = (k + 1) % 4;
                end
            end else begin
                for (int off = 0; off < 4; off++) begin
                    k = (rp[i] + off) % 4;
                    if (nown[i] < 0 && ivalid[k] && lowbit(idst[k]) == i && !held[k])
                        nown[i] = k;
                end
            end
        end
        for (int i = 0; i < 4; i++) own[i] = nown[i];
    endtask

    task automatic run_cycle(input bit use_row, input vec_t v, input string tag);
        logic [3:0]  eir, eov, eot;
        logic [31:0] eod;
        logic [15:0] ecf;
        @(negedge clk);
        if (use_row && v.c) begin
            check({tag, ".tbl.ovalid"}, 64'(ovalid), 64'(v.eov));
            check({tag, ".tbl.odata"},  64'(odata),  64'(v.eod));
            check({tag, ".tbl.otail"},  64'(otail),  64'(v.eot));
            check({tag, ".tbl.cfg"},    64'(cfg),    64'(v.ecf));
            check({tag, ".tbl.iready"}, 64'(iready), 64'(v.eir));
        end
        model_exp(eir, eov, eot, eod, ecf);
        check({tag, ".mdl.ovalid"}, 64'(ovalid), 64'(eov));
        check({tag, ".mdl.odata"},  64'(odata),  64'(eod));
        check({tag, ".mdl.otail"},  64'(otail),  64'(eot));
        check({tag, ".mdl.cfg"},    64'(cfg),    64'(ecf));
        check({tag, ".mdl.iready"}, 64'(iready), 64'(eir));
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t z;
        vec_t rr;
        rr = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        z  = rr;

        // 3-flit packet from input 0 to output 2
        tbl.push_back(mkv(0, 4'b0001, 32'h11, 16'h0004, 4'b0000, 4'hF, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 4'b0001, 32'h11, 16'h0004, 4'b0000, 4'hF, 1, 4'b0100, 32'h00110000, 4'b0000, 16'h0100, 4'b0001));
        tbl.push_back(mkv(0, 4'b0001, 32'h22, 16'h0004, 4'b0000, 4'hF, 1, 4'b0100, 32'h00220000, 4'b0000, 16'h0100, 4'b0001));
        tbl.push_back(mkv(0, 4'b0001, 32'h33, 16'h0004, 4'b0001, 4'hF, 1, 4'b0100, 32'h00330000, 4'b0100, 16'h0100, 4'b0001));
        tbl.push_back(mkv(0, 4'b0000, 32'h00, 16'h0000, 4'b0000, 4'hF, 1, 0, 0, 0, 0, 0));
        // inputs 1 and 3 contend for output 0
        tbl.push_back(rr);
        tbl.push_back(mkv(0, 4'b1010, 32'hD100B100, 16'h1010, 4'b1000, 4'hF, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 4'b1010, 32'hD100B100, 16'h1010, 4'b1000, 4'hF, 1, 4'b0001, 32'h000000B1, 4'b0000, 16'h0002, 4'b0010));
        tbl.push_back(mkv(0, 4'b1010, 32'hD100B200, 16'h1010, 4'b1010, 4'hF, 1, 4'b0001, 32'h000000B2, 4'b0001, 16'h0002, 4'b0010));
        tbl.push_back(mkv(0, 4'b1000, 32'hD1000000, 16'h1010, 4'b1000, 4'hF, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 4'b1000, 32'hD1000000, 16'h1010, 4'b1000, 4'hF, 1, 4'b0001, 32'h000000D1, 4'b0001, 16'h0008, 4'b1000));
        tbl.push_back(mkv(0, 4'b0000, 32'h0, 16'h0, 4'b0000, 4'hF, 1, 0, 0, 0, 0, 0));
        // single flit held under backpressure
        tbl.push_back(rr);
        tbl.push_back(mkv(0, 4'b0100, 32'h00A50000, 16'h0200, 4'b0100, 4'h0, 1, 0, 0, 0, 0, 0));
        for (int n = 0; n < 3; n++)
            tbl.push_back(mkv(0, 4'b0100, 32'h00A50000, 16'h0200, 4'b0100, 4'h0, 1, 4'b0010, 32'h0000A500, 4'b0010, 16'h0040, 4'b0000));
        tbl.push_back(mkv(0, 4'b0100, 32'h00A50000, 16'h0200, 4'b0100, 4'hF, 1, 4'b0010, 32'h0000A500, 4'b0010, 16'h0040, 4'b0100));
        tbl.push_back(mkv(0, 4'b0000, 32'h0, 16'h0, 4'b0000, 4'hF, 1, 0, 0, 0, 0, 0));
        // four inputs to four distinct outputs
        tbl.push_back(rr);
        tbl.push_back(mkv(0, 4'hF, 32'h44332211, 16'h4218, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 4'hF, 32'h44332211, 16'h4218, 4'hF, 4'hF, 1, 4'hF, 32'h11443322, 4'hF, 16'h1842, 4'hF));
        tbl.push_back(mkv(0, 4'h0, 32'h0, 16'h0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 0));
        // non-one-hot destination 0110 resolves to output 1
        tbl.push_back(rr);
        tbl.push_back(mkv(0, 4'b0001, 32'h5A, 16'h0006, 4'b0001, 4'hF, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 4'b0001, 32'h5A, 16'h0006, 4'b0001, 4'hF, 1, 4'b0010, 32'h00005A00, 4'b0010, 16'h0010, 4'b0001));
        tbl.push_back(mkv(0, 4'b0000, 32'h0, 16'h0, 4'b0000, 4'hF, 1, 0, 0, 0, 0, 0));
        // reset mid-packet, then a fresh head
        tbl.push_back(rr);
        tbl.push_back(mkv(0, 4'b0001, 32'h11, 16'h0004, 4'b0000, 4'hF, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 4'b0001, 32'h11, 16'h0004, 4'b0000, 4'hF, 1, 4'b0100, 32'h00110000, 4'b0000, 16'h0100, 4'b0001));
        tbl.push_back(mkv(1, 4'b0001, 32'h22, 16'h0004, 4'b0000, 4'hF, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 4'b0001, 32'h33, 16'h0004, 4'b0001, 4'hF, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 4'b0001, 32'h33, 16'h0004, 4'b0001, 4'hF, 1, 4'b0100, 32'h00330000, 4'b0100, 16'h0100, 4'b0001));
        tbl.push_back(mkv(0, 4'b0000, 32'h0, 16'h0, 4'b0000, 4'hF, 1, 0, 0, 0, 0, 0));

        rst = 1'b1; ivalid = '0; idata = '0; idst = '0; itail = '0; oready = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("reset.cfg",    64'(cfg),    64'h0);
        check("reset.ovalid", 64'(ovalid), 64'h0);
        check("reset.iready", 64'(iready), 64'h0);
        @(posedge clk);
        #1;

        for (int n = 0; n < tbl.size(); n++) begin
            rst    = tbl[n].r;
            ivalid = tbl[n].iv;
            idata  = tbl[n].id;
            idst   = tbl[n].ds;
            itail  = tbl[n].it;
            oready = tbl[n].ord;
            run_cycle(1'b1, tbl[n], $sformatf("vec%0d", n));
        end

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(299) == 0);
            for (int k = 0; k < 4; k++) begin
                ivalid[k] = ($urandom_range(3) != 0);
                itail[k]  = ($urandom_range(9) < 3);
                oready[k] = ($urandom_range(3) != 0);
                idata[k]  = 8'($urandom);
                if ($urandom_range(4) != 0) idst[k] = 4'b0001 << $urandom_range(3);
                else                        idst[k] = 4'($urandom);
            end
            run_cycle(1'b0, z, $sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
